// File: rtl/ascii_tx_pkg.sv
// Shared types and constants for the ASCII UART transmit path.
//
// Contents:
//   tx_state_t            - transmitter FSM state encoding
//   CASE_OFFSET           - offset removed by the input side for flagged characters
//   DEFAULT_CLKS_PER_BIT  - 100 MHz system clock at 115200 baud
//   DEFAULT_FIFO_DEPTH    - default character buffer depth
//   rebuild_char()        - undo the input-side case shift on a character-ROM address
package ascii_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] CASE_OFFSET = 8'd32;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;

  // Modulo-256 on purpose: high addresses wrap silently (0xF0 + 32 -> 0x10).
  function automatic logic [7:0] rebuild_char(input logic [7:0] addr, input logic f);
    logic [7:0] sum;
    sum = addr + CASE_OFFSET;
    return f ? sum : addr;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate read/write pointers and an occupancy count.
//
// Parameters:
//   WIDTH - data width in bits
//   DEPTH - number of entries; power of two, at least 2
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset; empties the FIFO
//   push  - write din this edge (ignored while full)
//   pop   - advance the read pointer this edge (ignored while empty)
//   din   - write data
//   dout  - head-of-queue data, valid whenever empty is low
//   full  - no free entries
//   empty - no stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Serial-output end of the character path.
//
// Rebuilds the ASCII byte from a character-ROM address and its case flag
// (flagged addresses get CASE_OFFSET added back), buffers bytes in a small
// FIFO and sends each as an 8N1 UART frame, LSB first. Frames are sent
// back-to-back without an idle bit while the FIFO holds data.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit
//   FIFO_DEPTH   - character buffer entries; power of two, at least 2
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset; truncates any frame in flight
//   in_valid - addr and f are valid this cycle
//   in_ready - a character can be accepted this cycle (FIFO not full)
//   addr     - character-ROM address
//   f        - case flag; 1 means the address was shifted down by CASE_OFFSET
//   tx       - registered UART serial line, idle high
//   busy     - frame in progress or characters still buffered
module ascii_uart_tx
  import ascii_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] addr,
  input  logic       f,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned      BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic             push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       char_byte;
  logic [7:0]       fifo_dout;
  logic             baud_last;

  // ---------------------------------------------------------------------------
  // Input side: rebuild the byte before it is buffered
  // ---------------------------------------------------------------------------
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign char_byte = rebuild_char(addr, f);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .din   (char_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          baud_d   = '0;
          state_d  = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state so the pin changes on the
  // same edge as the state, from a flop rather than from decode logic.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Self-checking bench for ascii_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-based model predicts tx/busy/in_ready every cycle from frame
// position; directed sections pin the model with hand-computed values.
module tb_ascii_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] addr;
  logic       f;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ascii_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .f        (f),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural model: a byte queue plus the position inside the current frame
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_acc;
  logic [7:0] m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      m_acc = in_valid && (mq.size() < D);
      m_b   = f ? 8'((int'(addr) + 32) % 256) : addr;
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          if (mq.size() > 0) begin
            m_byte = mq.pop_front();
            m_t    = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_t = m_t + 1;
        end
      end else if (mq.size() > 0) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (m_acc) mq.push_back(m_b);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / C;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(negedge clk) begin
    logic e_tx, e_busy, e_rdy;
    if (!rst) begin
      e_tx   = exp_tx();
      e_busy = m_active || (mq.size() > 0);
      e_rdy  = (mq.size() < D);
      checks++;
      if (tx !== e_tx || busy !== e_busy || in_ready !== e_rdy) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d tx=%b/%b busy=%b/%b in_ready=%b/%b (actual/required)",
                 cyc, tx, e_tx, busy, e_busy, in_ready, e_rdy);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] a, input logic ff);
    int n;
    n        = 0;
    addr     = a;
    f        = ff;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge of a frame's first cycle; samples one cycle per bit.
  task automatic recv_frame(output logic [7:0] b, output logic ok);
    logic [9:0] s;
    s[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (C) @(negedge clk);
      s[i] = tx;
    end
    b  = s[8:1];
    ok = (s[0] == 1'b0) && (s[9] == 1'b1);
  endtask

  // Single character into an idle block, with exact timing checks.
  task automatic one_char(input logic [7:0] a, input logic ff, input logic [7:0] want,
                          input string name);
    logic [7:0] b;
    logic       ok;
    send(a, ff);
    check({name, "_tx_before_start"}, 32'(tx), 32'd1);
    check({name, "_busy_queued"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({name, "_tx_start"}, 32'(tx), 32'd0);
    recv_frame(b, ok);
    check({name, "_byte"}, 32'(b), 32'(want));
    check({name, "_framing"}, 32'(ok), 32'd1);
    repeat (C - 1) @(negedge clk);
    check({name, "_busy_last_stop_cycle"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({name, "_busy_after_frame"}, 32'(busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         hi;
    int         n;
    int         acc1;
    int         acc5;
    int         acc6;
    int         gap;
    logic [7:0] six_a [6];
    logic       six_f [6];

    rst      = 1'b1;
    in_valid = 1'b0;
    addr     = 8'h00;
    f        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release_busy", 32'(busy), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("idle_50_high", 32'(hi), 32'd50);

    one_char(8'h41, 1'b0, 8'h41, "a41_f0");
    one_char(8'h41, 1'b1, 8'h61, "a41_f1");
    one_char(8'hF0, 1'b1, 8'h10, "wrap_f0");

    // Six characters with in_valid held high.
    six_a = '{8'h48, 8'h45, 8'h2C, 8'h4C, 8'h4F, 8'h21};
    six_f = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    acc1  = 0;
    acc5  = 0;
    acc6  = 0;
    for (int i = 0; i < 6; i++) begin
      send(six_a[i], six_f[i]);
      if (i == 0) acc1 = cyc;
      if (i == 4) begin
        acc5 = cyc;
        check("six_ready_low_after_fifth", 32'(in_ready), 32'd0);
      end
      if (i == 5) acc6 = cyc;
    end
    check("six_first_five_contiguous", 32'(acc5 - acc1), 32'd4);
    check("six_sixth_accept_edge", 32'(acc6 - acc1), 32'd42);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("six_total_length", 32'(cyc - acc1), 32'd241);

    // Reset in the DATA phase of frame two with two bytes still queued.
    repeat (5) @(negedge clk);
    send(8'h5A, 1'b0);
    acc1 = cyc;
    send(8'h00, 1'b0);
    send(8'h33, 1'b1);
    send(8'h7E, 1'b0);
    while (cyc < acc1 + 60) @(negedge clk);
    check("rst_pre_tx_low", 32'(tx), 32'd0);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_tx_high", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_busy", 32'(busy), 32'd0);
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) hi++;
    end
    check("rst_no_residual_frames", 32'(hi), 32'd60);
    one_char(8'h41, 1'b1, 8'h61, "post_rst");

    // Randomised traffic: bursts that fill the FIFO mixed with idle gaps.
    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : 0;
      repeat (gap) @(negedge clk);
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("random_drain", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
